shift_unit_arbiter: RTL and testbench
=====================================

// Module: shift_unit_arbiter
// PURPOSE
//  Shares one 32-bit barrel shifter (SLL/SRL/SRA) between NREQ requesters, e.g. the ALU and the decryption core.
//  Arbitration is round-robin. Each requester has a valid/ready handshake.
//  The result is registered and tagged with the requester id. It is held until the consumer accepts it.
//  The block sits beside the ALU. It lets the decryption core borrow shift bandwidth without a second shifter.
// PARAMETERS
//  WIDTH    32  operand/result width (only 32 is supported)
//  SHAMT_W  5   shift-amount width; only the low 5 bits are used
//  NREQ     2   number of requesters; 2..4 are supported
//  ID_W     2   width of resp_id; must be >= clog2(NREQ)
// PORTS
//  clock      in   1             single clock; all state updates on the rising edge
//  reset_n    in   1             asynchronous, active-low reset
//  req_valid  in   NREQ          requester i holds a request
//  req_ready  out  NREQ          request i is accepted this cycle (one-hot or zero)
//  req_data   in   NREQ*WIDTH    operand A; slice i = [i*WIDTH +: WIDTH]
//  req_shamt  in   NREQ*SHAMT_W  shift amount; slice i
//  req_op     in   NREQ*2        op: 00 SLL, 01 SRL, 10 SRA, 11 PASS (A unchanged)
//  resp_valid out  1             resp_data/resp_id are valid
//  resp_ready in   1             consumer accepts the response
//  resp_data  out  WIDTH         shifted result
//  resp_id    out  ID_W          index of the requester that produced resp_data
//  busy       out  1             resp_valid & ~resp_ready (result register stalled)
// BEHAVIOUR
//  - Reset (async assert, sync release): resp_valid=0, resp_data=0, resp_id=0.
//    The last-grant pointer resets to NREQ-1, so requester 0 wins the first tie.
//  - accept_en = ~resp_valid | resp_ready. This gives full throughput: one transfer per cycle, with no bubble on back-to-back requests.
//  - Grant: the first valid requester scanning from (last_grant+1) mod NREQ upward, with wrap-around.
//    req_ready[i] = accept_en & grant[i]. The signal is combinational from req_valid and state.
//    Requesters must not make req_valid depend on req_ready.
//  - Transfer = req_valid[i] & req_ready[i]. On a transfer:
//    resp_data <= shift(req_data_i, req_shamt_i, req_op_i); resp_id <= i; resp_valid <= 1; last_grant <= i.
//  - No transfer while accept_en=1: resp_valid <= 0. resp_data and resp_id hold their previous values.
//  - accept_en=0 (stall): every req_ready is 0, and resp_* holds stable until resp_ready=1.
//  - Latency: a request accepted in cycle N has its response visible (resp_valid=1) in cycle N+1.
//  - The pointer advances only on a transfer. Idle cycles and stalled cycles leave it unchanged.
//  - Fairness: a requester that holds valid is granted within NREQ transfers.
//  - Requesters must hold valid, data, shamt and op stable until accepted. The block does not check this.
//  - Shift rules:
//    - SLL fills with 0.
//    - SRL fills with 0.
//    - SRA fills with bit WIDTH-1.
//    - shamt=0 returns A for every op.
//    - shamt=31 under SRA returns all copies of A[31].
//  - Simultaneous resp_ready=1 and a new request: the old response retires and the new one loads in the same edge.
//  - Reset mid-operation: a pending response is dropped, with no resp_valid pulse. Requesters must re-issue.
// STRUCTURE
//  - Shared package shift_pkg holds:
//    - op constants SH_OP_SLL=2'b00, SH_OP_SRL=2'b01, SH_OP_SRA=2'b10, SH_OP_PASS=2'b11;
//    - localparams WIDTH and SHAMT_W.
//  - Sub-module shift_core (combinational): a 5-stage log shifter (16/8/4/2/1).
//    Each stage is a 2:1 mux selected by one shamt bit. Fill is chosen by op.
//    One instance, fed by a NREQ:1 operand mux driven by the grant.
//  - This module contains only the arbiter, the pointer, the result register and the handshake logic.
// TESTING
//  1. Reset: reset_n=0 mid-run -> resp_valid=0, resp_id=0, resp_data=0 immediately.
//     After release, req_valid=2'b11 -> req_ready=2'b01 on the first cycle.
//  2. Single request: req0 A=32'h8000_00F0, shamt=4, SRA -> next cycle resp_data=32'hF800_000F, resp_id=0.
//     Same operand with SRL -> 32'h0800_000F.
//  3. Round-robin: both requesters valid for 4 cycles with resp_ready=1 -> grants 0,1,0,1.
//     resp_id follows one cycle later. resp_valid stays 1 throughout.
//  4. Back-pressure: resp_ready=0 for 3 cycles while both are valid -> req_ready=0, and resp_data/resp_id are held.
//     On resp_ready=1 the next grant goes to the requester after the last one granted.
//  5. Boundaries:
//     - SLL A=32'h0000_0001 shamt=31 -> 32'h8000_0000;
//     - SRA A=32'h8000_0000 shamt=31 -> 32'hFFFF_FFFF;
//     - any op with shamt=0 -> A;
//     - PASS -> A.
//  6. Reset with resp_valid=1 and resp_ready=0 -> the response is dropped and never observed.
//     After release the pointer prefers requester 0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift unit arbiter:
// operation encodings, datapath widths and the operand bundle.
package shift_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] SH_OP_SLL  = 2'b00;
    localparam logic [1:0] SH_OP_SRL  = 2'b01;
    localparam logic [1:0] SH_OP_SRA  = 2'b10;
    localparam logic [1:0] SH_OP_PASS = 2'b11;

    typedef struct packed {
        logic [WIDTH-1:0]   a;
        logic [SHAMT_W-1:0] shamt;
        logic [1:0]         op;
    } sh_req_t;

endpackage

// File: rtl/shift_core.sv
// Combinational logarithmic barrel shifter: one 2:1 mux stage per
// shamt bit, largest distance first, fill bit chosen by the op.
module shift_core
    import shift_pkg::*;
(
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic [WIDTH-1:0]   y
);

    logic left;
    logic fill;

    assign left = (op == SH_OP_SLL);
    assign fill = (op == SH_OP_SRA) ? a[WIDTH-1] : 1'b0;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int N = 1 << (SHAMT_W - 1 - k);

        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] sl;
        logic [WIDTH-1:0] sr;
        logic [WIDTH-1:0] y;

        if (k == 0) begin : g_first
            assign x = a;
        end else begin : g_next
            assign x = g_stage[k-1].y;
        end

        assign sl = {x[WIDTH-1-N:0], {N{1'b0}}};
        assign sr = {{N{fill}}, x[WIDTH-1:N]};
        assign y  = shamt[SHAMT_W-1-k] ? (left ? sl : sr) : x;
    end

    assign y = (op == SH_OP_PASS) ? a : g_stage[SHAMT_W-1].y;

endmodule

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between NREQ requesters;
// registered, id-tagged result with a valid/ready response handshake.
module shift_unit_arbiter #(
    parameter int WIDTH   = shift_pkg::WIDTH,
    parameter int SHAMT_W = shift_pkg::SHAMT_W,
    parameter int NREQ    = 2,
    parameter int ID_W    = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic [NREQ*SHAMT_W-1:0] req_shamt,
    input  logic [NREQ*2-1:0]       req_op,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [WIDTH-1:0]        resp_data,
    output logic [ID_W-1:0]         resp_id,
    output logic                    busy
);

    import shift_pkg::*;

    logic [ID_W-1:0]  last_grant;
    logic [NREQ-1:0]  grant;
    logic [ID_W-1:0]  gidx;
    logic             found;
    logic             accept_en;
    logic             transfer;
    sh_req_t          sel;
    logic [WIDTH-1:0] shift_y;

    assign accept_en = ~resp_valid | resp_ready;
    assign transfer  = accept_en & found;
    assign req_ready = accept_en ? grant : '0;
    assign busy      = resp_valid & ~resp_ready;

    // Two passes: indices above the last grant first, then wrap around.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && (i > int'(last_grant))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gidx     = ID_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && (i <= int'(last_grant))) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gidx     = ID_W'(i);
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel.a     = req_data[i*WIDTH +: WIDTH];
                sel.shamt = req_shamt[i*SHAMT_W +: SHAMT_W];
                sel.op    = req_op[i*2 +: 2];
            end
        end
    end

    shift_core u_core (
        .a     (sel.a),
        .shamt (sel.shamt),
        .op    (sel.op),
        .y     (shift_y)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            last_grant <= ID_W'(NREQ - 1);
        end else if (accept_en) begin
            resp_valid <= transfer;
            if (transfer) begin
                resp_data  <= shift_y;
                resp_id    <= gidx;
                last_grant <= gidx;
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Bench for shift_unit_arbiter: directed vector table, hand-written
// arbitration/stall/reset sequences and a randomized model comparison.
module tb_shift_unit_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 32;
    localparam int SW   = 5;

    logic              clock;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ*SW-1:0] req_shamt;
    logic [NREQ*2-1:0] req_op;
    logic              resp_valid;
    logic              resp_ready;
    logic [W-1:0]      resp_data;
    logic [1:0]        resp_id;
    logic              busy;

    int vectors;
    int miscompares;

    shift_unit_arbiter #(.NREQ(NREQ), .ID_W(2)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_shamt  (req_shamt),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [4:0]  sh;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference shift computed with plain language operators.
    function automatic logic [31:0] ref_shift(input logic [31:0] a,
                                              input logic [4:0] s,
                                              input logic [1:0] op);
        case (op)
            2'b00:   return a << s;
            2'b01:   return a >> s;
            2'b10:   return 32'($signed(a) >>> s);
            default: return a;
        endcase
    endfunction

    task automatic put(input int i, input logic [31:0] a,
                       input logic [4:0] s, input logic [1:0] op);
        req_data[i*W +: W]    = a;
        req_shamt[i*SW +: SW] = s;
        req_op[i*2 +: 2]      = op;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Random-phase model state
    logic        m_valid;
    logic [31:0] m_data;
    int          m_id;
    int          m_ptr;
    logic        pv [NREQ];
    logic [31:0] pa [NREQ];
    logic [4:0]  ps [NREQ];
    logic [1:0]  po [NREQ];

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        req_shamt   = '0;
        req_op      = '0;
        resp_ready  = 1'b1;

        tbl[0]  = '{0, 32'h8000_00F0, 5'd4,  2'b10, 32'hF800_000F};
        tbl[1]  = '{0, 32'h8000_00F0, 5'd4,  2'b01, 32'h0800_000F};
        tbl[2]  = '{1, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000};
        tbl[3]  = '{1, 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF};
        tbl[4]  = '{0, 32'hA5A5_1234, 5'd0,  2'b00, 32'hA5A5_1234};
        tbl[5]  = '{1, 32'hA5A5_1234, 5'd0,  2'b01, 32'hA5A5_1234};
        tbl[6]  = '{0, 32'hA5A5_1234, 5'd0,  2'b10, 32'hA5A5_1234};
        tbl[7]  = '{1, 32'hDEAD_BEEF, 5'd7,  2'b11, 32'hDEAD_BEEF};
        tbl[8]  = '{0, 32'h1234_5678, 5'd8,  2'b00, 32'h3456_7800};
        tbl[9]  = '{1, 32'hF000_0000, 5'd16, 2'b10, 32'hFFFF_F000};
        tbl[10] = '{0, 32'h8765_4321, 5'd1,  2'b01, 32'h43B2_A190};
        tbl[11] = '{1, 32'h0F0F_0F0F, 5'd3,  2'b10, 32'h01E1_E1E1};

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        req_valid = 2'b11;
        #1;
        chk("first_tie", 32'(req_ready), 32'd1);
        req_valid = 2'b00;

        // Directed vector table, one requester at a time
        for (int v = 0; v < 12; v++) begin
            @(negedge clock);
            put(tbl[v].id, tbl[v].a, tbl[v].sh, tbl[v].op);
            req_valid  = NREQ'(1 << tbl[v].id);
            resp_ready = 1'b1;
            #1;
            chk($sformatf("tbl%0d_ready", v), 32'(req_ready),
                32'(1 << tbl[v].id));
            @(negedge clock);
            req_valid = '0;
            #1;
            chk($sformatf("tbl%0d_valid", v), 32'(resp_valid), 32'd1);
            chk($sformatf("tbl%0d_data", v), resp_data, tbl[v].exp);
            chk($sformatf("tbl%0d_id", v), 32'(resp_id), 32'(tbl[v].id));
        end

        // Round-robin with both requesters continuously valid
        pulse_reset();
        put(0, 32'h1111_1111, 5'd0, 2'b11);
        put(1, 32'h2222_2222, 5'd0, 2'b11);
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("rr%0d_ready", c), 32'(req_ready),
                (c % 2 == 0) ? 32'd1 : 32'd2);
            if (c > 0) begin
                chk($sformatf("rr%0d_valid", c), 32'(resp_valid), 32'd1);
                chk($sformatf("rr%0d_id", c), 32'(resp_id), 32'((c - 1) % 2));
            end
            @(negedge clock);
        end

        // Back-pressure: response from requester 1 must hold
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d_id", c), 32'(resp_id), 32'd1);
            chk($sformatf("bp%0d_data", c), resp_data, 32'h2222_2222);
            chk($sformatf("bp%0d_busy", c), 32'(busy), 32'd1);
            @(negedge clock);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'd1);

        // Reset while a response is stalled
        @(negedge clock);
        resp_ready = 1'b0;
        req_valid  = 2'b00;
        #1;
        chk("pend_valid", 32'(resp_valid), 32'd1);
        chk("pend_id", 32'(resp_id), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_data", resp_data, 32'd0);
        chk("mid_rst_id", 32'(resp_id), 32'd0);
        @(negedge clock);
        reset_n    = 1'b1;
        resp_ready = 1'b1;
        @(negedge clock);
        #1;
        chk("post_rst_valid", 32'(resp_valid), 32'd0);
        req_valid = 2'b11;
        #1;
        chk("post_rst_tie", 32'(req_ready), 32'd1);
        req_valid = 2'b00;

        // Randomized traffic against the reference model
        pulse_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_ptr   = NREQ - 1;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int   g;
            logic accept;
            logic [NREQ-1:0] exp_ready;
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
                    pv[i] = 1'b1;
                    pa[i] = $urandom;
                    ps[i] = 5'($urandom_range(0, 31));
                    po[i] = 2'($urandom_range(0, 3));
                end
                put(i, pa[i], ps[i], po[i]);
                req_valid[i] = pv[i];
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            accept = !m_valid || resp_ready;
            g = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (g < 0 && pv[j]) g = j;
            end
            exp_ready = (accept && g >= 0) ? NREQ'(1 << g) : '0;
            chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
            chk("rnd_valid", 32'(resp_valid), 32'(m_valid));
            chk("rnd_busy", 32'(busy), 32'(m_valid && !resp_ready));
            if (m_valid) begin
                chk("rnd_data", resp_data, m_data);
                chk("rnd_id", 32'(resp_id), 32'(m_id));
            end
            if (accept) begin
                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_data  = ref_shift(pa[g], ps[g], po[g]);
                    m_id    = g;
                    m_ptr   = g;
                    pv[g]   = 1'b0;
                end else begin
                    m_valid = 1'b0;
                end
            end
            @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
